// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle adder, CHUNK bits per clock with in-chunk lookahead; define ADDER_SUB_EN for the sub port
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] ra, rb, eff_b;
  logic carry, eff_cin, accept, last, pp;
  logic [IW-1:0] idx;
  logic [CHUNK-1:0] ca, cb, g, p, cs;
  logic [CHUNK:0] c;
`ifdef ADDER_SUB_EN
  assign eff_b   = sub ? ~b : b;
  assign eff_cin = sub | cin;
`else
  assign eff_b   = b;
  assign eff_cin = cin;
`endif
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign accept    = in_valid & in_ready;
  assign last      = idx == LAST;
  assign ca = ra[idx*CHUNK +: CHUNK];
  assign cb = rb[idx*CHUNK +: CHUNK];
  assign g  = ca & cb;
  assign p  = ca | cb;
  assign cs = ca ^ cb ^ c[CHUNK-1:0];
  // two-level lookahead: each carry is an OR of generate terms gated by the propagate chain, seeded by the carry register
  always_comb begin
    c = '0;
    pp = 1'b0;
    c[0] = carry;
    for (int i = 0; i < CHUNK; i++) begin
      c[i+1] = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & carry);
    end
  end
  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end
  // next state: accept in IDLE, finish on last chunk, release on result handshake
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (accept ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) :
                               (out_ready ? IDLE : DONE);
  end
  // datapath: latch operands on accept, then fold in one chunk per cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ra <= '0;
      rb <= '0;
      carry <= 1'b0;
      idx <= '0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else if (accept) begin
      ra <= a;
      rb <= eff_b;
      carry <= eff_cin;
      idx <= '0;
    end else if (state == RUN) begin
      sum[idx*CHUNK +: CHUNK] <= cs;
      carry <= c[CHUNK];
      idx <= last ? '0 : idx + 1'b1;
      if (last) begin
        cout <= c[CHUNK];
        ovf <= c[CHUNK] ^ c[CHUNK-1];
      end
    end
  end
endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: directed scenarios on an 8/2 instance plus a random sweep over CHUNK 1,2,4,8
module tb_chunked_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int chk_cnt = 0;
  int pass_cnt = 0;
  logic rst_d, rst_s;
  logic d_iv, d_ir, d_cin, d_sub, d_ov, d_or, d_cout, d_ovf;
  logic [7:0] d_a, d_b, d_sum;
  logic [9:0] q_d[$];
  int acc_d;

  task automatic chk(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // reference: plain integer arithmetic; returns {ovf, cout, sum}
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y0, input logic c0, input logic s);
    logic [7:0] y;
    logic c;
    int u, v;
    y = s ? ~y0 : y0;
    c = s | c0;
    u = int'(x) + int'(y) + int'(c);
    v = int'($signed(x)) + int'($signed(y)) + int'(c);
    return {(v > 127 || v < -128), (u > 255), u[7:0]};
  endfunction

  chunked_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .reset_n(rst_d), .in_valid(d_iv), .in_ready(d_ir),
    .a(d_a), .b(d_b), .cin(d_cin),
`ifdef ADDER_SUB_EN
    .sub(d_sub),
`endif
    .out_valid(d_ov), .out_ready(d_or), .sum(d_sum), .cout(d_cout), .ovf(d_ovf)
  );

  initial begin : dmon
    logic [9:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_d && d_ov && d_or) begin
        if (q_d.size() == 0) chk("d_unexpected", 1, 0);
        else begin
          e = q_d.pop_front();
          chk("d_sum", d_sum, e[7:0]);
          chk("d_cout", d_cout, e[8]);
          chk("d_ovf", d_ovf, e[9]);
        end
      end
    end
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic c, input logic s);
    d_a = x; d_b = y; d_cin = c; d_sub = s; d_iv = 1'b1;
    for (int k = 0; k < 50 && !d_ir; k++) @(negedge clk);
    chk("d_accept_ready", d_ir, 1);
    q_d.push_back(model(x, y, c, s));
    acc_d = cyc + 1;
    @(negedge clk);
    d_iv = 1'b0; d_a = 8'($urandom); d_b = 8'($urandom); d_cin = 1'($urandom);
  endtask

  task automatic take();
    for (int k = 0; k < 50 && !d_ov; k++) @(negedge clk);
    chk("d_latency", cyc - acc_d, 4);
    d_or = 1'b1;
    @(negedge clk);
    d_or = 1'b0;
  endtask

  for (genvar g = 0; g < 4; g++) begin : sw
    localparam int C = 1 << g;
    localparam int N = 8 / C;
    logic iv, ir, cn, sb, ov, orr, co, of;
    logic [7:0] x, y, s;
    logic [9:0] q[$];
    int acc[$];
    bit done = 1'b0;
    chunked_adder #(.WIDTH(8), .CHUNK(C)) u (
      .clk(clk), .reset_n(rst_s), .in_valid(iv), .in_ready(ir),
      .a(x), .b(y), .cin(cn),
`ifdef ADDER_SUB_EN
      .sub(sb),
`endif
      .out_valid(ov), .out_ready(orr), .sum(s), .cout(co), .ovf(of)
    );
    initial begin : drv
      iv = 1'b0; x = '0; y = '0; cn = 1'b0; sb = 1'b0;
      wait (rst_s === 1'b1);
      for (int n = 0; n < 1000; n++) begin
        @(negedge clk);
        x = (n % 7 == 0) ? 8'hFF : (n % 13 == 0) ? 8'h80 : 8'($urandom);
        y = (n % 5 == 0) ? 8'hFF : (n % 11 == 0) ? 8'h7F : 8'($urandom);
        cn = 1'($urandom);
`ifdef ADDER_SUB_EN
        sb = 1'($urandom);
`endif
        iv = 1'b1;
        for (int k = 0; k < 200 && !ir; k++) @(negedge clk);
        chk($sformatf("sw%0d_ready", C), ir, 1);
        q.push_back(model(x, y, cn, sb));
        acc.push_back(cyc + 1);
        @(negedge clk);
        iv = 1'b0; x = 8'($urandom); y = 8'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
      chk($sformatf("sw%0d_drain", C), q.size(), 0);
      done = 1'b1;
    end
    initial begin : mon
      logic [9:0] e;
      int a0;
      bit got;
      got = 1'b0; orr = 1'b0; e = '0;
      forever begin
        @(negedge clk);
        if (ov) begin
          if (!got) begin
            if (q.size() == 0) chk($sformatf("sw%0d_unexpected", C), 1, 0);
            else begin
              e = q.pop_front();
              a0 = acc.pop_front();
              chk($sformatf("sw%0d_latency", C), cyc - a0, N);
              chk($sformatf("sw%0d_result", C), {of, co, s}, e);
            end
            got = 1'b1;
          end else chk($sformatf("sw%0d_hold", C), {of, co, s}, e);
          orr = $urandom_range(0, 2) != 0;
          if (orr) got = 1'b0;
        end else orr = 1'($urandom);
      end
    end
  end

  initial begin : main
    logic [9:0] e;
    rst_d = 1'b0; rst_s = 1'b0;
    d_iv = 1'b0; d_or = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", d_ov, 0);
    chk("rst_sum", d_sum, 0);
    chk("rst_cout", d_cout, 0);
    chk("rst_ovf", d_ovf, 0);
    rst_d = 1'b1; rst_s = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", d_ir, 1);
    send(8'hFF, 8'h01, 1'b0, 1'b0); take();
    send(8'h7F, 8'h01, 1'b0, 1'b0); take();
    send(8'h80, 8'h80, 1'b1, 1'b0); take();
`ifdef ADDER_SUB_EN
    send(8'h05, 8'h07, 1'b0, 1'b1); take();
    send(8'h07, 8'h05, 1'b1, 1'b1); take();
    d_sub = 1'b0;
`endif
    send(8'h3C, 8'h4D, 1'b0, 1'b0);
    e = model(8'h3C, 8'h4D, 1'b0, 1'b0);
    for (int k = 0; k < 50 && !d_ov; k++) @(negedge clk);
    d_iv = 1'b1; d_a = 8'h11; d_b = 8'h22; d_cin = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", d_ir, 0);
      chk("bp_out_valid", d_ov, 1);
      chk("bp_hold", {d_ovf, d_cout, d_sum}, e);
    end
    d_or = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", d_ir, 1);
    d_or = 1'b0; d_iv = 1'b0;
    repeat (8) @(negedge clk);
    chk("bp_no_accept", d_ov, 0);
    send(8'h33, 8'h44, 1'b0, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_d = 1'b0;
    #1;
    chk("arst_out_valid", d_ov, 0);
    chk("arst_sum", d_sum, 0);
    chk("arst_cout", d_cout, 0);
    chk("arst_in_ready", d_ir, 1);
    void'(q_d.pop_back());
    @(negedge clk);
    rst_d = 1'b1;
    @(negedge clk);
    chk("arst_release_ready", d_ir, 1);
    send(8'h10, 8'h20, 1'b0, 1'b0); take();
    repeat (2) @(negedge clk);
    chk("d_drain", q_d.size(), 0);
    for (int k = 0; k < 60000 && !(sw[0].done && sw[1].done && sw[2].done && sw[3].done); k++) @(negedge clk);
    chk("sweep_done", int'(sw[0].done && sw[1].done && sw[2].done && sw[3].done), 1);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/chunked_adder.md
# chunked_adder

Parametrised multi-cycle adder that adds two WIDTH-bit operands plus carry-in, processing CHUNK bits per clock with a lookahead carry inside each chunk and a registered carry between chunks. It is the next generation of our small fixed-width carry-out adder. It adds a full sum, carry-out and signed overflow, valid/ready handshakes, and optional subtraction. It sits between operand producers and result consumers where area matters more than single-cycle latency.

## Interface
- WIDTH, 32, operand/sum width in bits; must be a positive multiple of CHUNK.
- CHUNK, 2, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH.
- Derived: NCHUNK = WIDTH/CHUNK.
- clk  input  1  single clock; all state changes on rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- sub  input  1  subtract select; exists only with ADDER_SUB_EN.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result bits.
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE. All registers clear: sum=0, cout=0, ovf=0, out_valid=0.
- in_ready = (state==IDLE). in_ready is 1 immediately after reset release.
- IDLE: when in_valid&in_ready, latch a, b and effective carry-in, set chunk index=0, and go to RUN.
- Effective carry-in is cin, or 1 when sub=1 in the configured build. The latched b is ~b when sub=1.
- Operand pins are don't-care after the accept edge.
- RUN, each cycle: process chunk idx, bits [idx*CHUNK +: CHUNK].
  - Generate g=a&b and propagate p=a|b per bit.
  - Lookahead carries within the chunk are seeded by the carry register.
  - Write the chunk's sum bits into the sum register and update the carry register.
  - Increment idx.
- Last chunk (idx==NCHUNK-1): also register cout and ovf, set out_valid=1, and go to DONE.
- DONE: sum, cout and ovf are held stable while out_valid=1. On out_valid&out_ready, out_valid→0 and state→IDLE.
- sum bits of chunks not yet processed may hold stale values during RUN. Consumers only sample when out_valid=1.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); exact for all operand values.
- Reset mid-RUN or mid-DONE: operation is aborted with no result delivered, and all outputs return to reset values asynchronously.

## Timing
- Accept at edge T0. out_valid rises at edge T0+NCHUNK; with CHUNK=WIDTH it rises at T0+1.
- Result handshake at edge T1 → in_ready=1 from T1 onward; the next accept is possible at edge T1+1.
- Minimum issue interval is NCHUNK+2 cycles when out_ready is held at 1.
- in_valid while in_ready=0 is ignored; the producer must hold its request.
- in_ready, out_valid, sum, cout and ovf are all driven from registers or the state register. There is no combinational path from in_valid or out_ready to any output.

## Configuration
- ADDER_SUB_EN defined: the sub port exists. sub=1 computes a − b as a + ~b + 1, ignoring cin.
  - cout=1 means no borrow.
  - ovf is the signed subtraction overflow.
- ADDER_SUB_EN undefined: there is no sub port and the block is add-only; logic is otherwise identical.

## Test plan
- WIDTH=8, CHUNK=2: a=8'hFF, b=8'h01, cin=0, accept at T0 → out_valid at T0+4, sum=8'h00, cout=1, ovf=0.
- a=8'h7F, b=8'h01, cin=0 → sum=8'h80, cout=0, ovf=1. Then a=8'h80, b=8'h80, cin=1 → sum=8'h01, cout=1, ovf=1.
- ADDER_SUB_EN, sub=1, a=8'h05, b=8'h07 → sum=8'hFE, cout=0, ovf=0. Then a=8'h07, b=8'h05 → sum=8'h02, cout=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid → sum/cout/ovf stable and in_ready=0. A new in_valid with a=8'h11 is not accepted. Raise out_ready → in_ready=1 on the next cycle.
- Reset: deassert reset_n at T0+2 during RUN → out_valid=0, sum=0, state IDLE immediately. After release, in_ready=1 and a fresh add (8'h10+8'h20) gives 8'h30.
- Sweep: WIDTH=8 with CHUNK ∈ {1,2,4,8}, 1000 random operands each → {cout,sum} matches the reference model, and out_valid latency equals NCHUNK (8, 4, 2 or 1 cycles).
